line_clear_engine: RTL

LINE_CLEAR_ENGINE -- requirements
Module: line_clear_engine

---
 rtl/tetris_pkg.sv | 36 +++
 rtl/row_collapse.sv | 22 ++
 rtl/line_clear_engine.sv | 119 +++++++++++
 3 files changed

// File: rtl/tetris_pkg.sv
// Shared field geometry, FSM states and score table for the line-clear engine.
package tetris_pkg;

  localparam int ROWS       = 20;
  localparam int COLS       = 20;
  localparam int FIELD_BITS = ROWS * COLS;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } state_t;

  localparam logic [15:0] SCORE_K1 = 16'd40;
  localparam logic [15:0] SCORE_K2 = 16'd100;
  localparam logic [15:0] SCORE_K3 = 16'd300;
  localparam logic [15:0] SCORE_K4 = 16'd1200;

  function automatic logic [15:0] score_step(
    input logic [15:0] s,
    input logic [4:0]  k
  );
    logic [15:0] add;
    logic [16:0] sum;
    unique case (1'b1)
      (k == 5'd0): add = 16'd0;
      (k == 5'd1): add = SCORE_K1;
      (k == 5'd2): add = SCORE_K2;
      (k == 5'd3): add = SCORE_K3;
      default:     add = SCORE_K4;
    endcase
    sum = {1'b0, s} + {1'b0, add};
    return sum[16] ? 16'hFFFF : sum[15:0];
  endfunction

endpackage

// File: rtl/row_collapse.sv
// Removes one row from the field: rows above it drop by one, zeros enter row 0.
module row_collapse #(
  parameter int ROWS = 20,
  parameter int COLS = 20,
  parameter int PW   = 5
) (
  input  logic [ROWS*COLS-1:0] field,
  input  logic [PW-1:0]        row,
  output logic [ROWS*COLS-1:0] collapsed
);

  always_comb begin
    collapsed = '0;
    for (int i = 0; i < ROWS; i++) begin
      if (PW'(i) > row)
        collapsed[i*COLS +: COLS] = field[i*COLS +: COLS];
      else if (i != 0)
        collapsed[i*COLS +: COLS] = field[(i-1)*COLS +: COLS];
    end
  end

endmodule

// File: rtl/line_clear_engine.sv
// Scans a settled field bottom-up, removing full rows one per cycle.
// Define LINE_CLEAR_SCORE_EN to build the saturating score accumulator.
module line_clear_engine #(
  parameter int ROWS = tetris_pkg::ROWS,
  parameter int COLS = tetris_pkg::COLS
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [ROWS*COLS-1:0] field_in,
  output logic                 busy,
  output logic                 done,
  output logic [ROWS*COLS-1:0] field_out,
  output logic [4:0]           lines_cleared,
  output logic [15:0]          score
);

  import tetris_pkg::*;

  localparam int FB = ROWS * COLS;
  localparam int PW = (ROWS > 1) ? $clog2(ROWS) : 1;

  state_t        state_q, state_d;
  logic [FB-1:0] work_q, work_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [4:0]    cnt_q, cnt_d;
  logic [FB-1:0] fout_d;
  logic [4:0]    lc_d;
  logic          done_d;
  logic [FB-1:0] collapsed;
  logic          row_full;

  row_collapse #(
    .ROWS (ROWS),
    .COLS (COLS),
    .PW   (PW)
  ) u_collapse (
    .field     (work_q),
    .row       (ptr_q),
    .collapsed (collapsed)
  );

  assign row_full = &work_q[int'(ptr_q)*COLS +: COLS];
  assign busy     = (state_q != IDLE);

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    fout_d  = field_out;
    lc_d    = lines_cleared;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          work_d  = field_in;
          ptr_d   = PW'(ROWS - 1);
          cnt_d   = '0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        // Pointer holds on a cleared row: the row above has just dropped in.
        if (row_full) begin
          work_d = collapsed;
          cnt_d  = cnt_q + 5'd1;
        end else if (ptr_q == '0) begin
          state_d = DONE;
        end else begin
          ptr_d = ptr_q - PW'(1);
        end
      end
      DONE: begin
        fout_d  = work_q;
        lc_d    = cnt_q;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      work_q        <= '0;
      ptr_q         <= PW'(ROWS - 1);
      cnt_q         <= '0;
      field_out     <= '0;
      lines_cleared <= '0;
      done          <= 1'b0;
    end else begin
      state_q       <= state_d;
      work_q        <= work_d;
      ptr_q         <= ptr_d;
      cnt_q         <= cnt_d;
      field_out     <= fout_d;
      lines_cleared <= lc_d;
      done          <= done_d;
    end
  end

`ifdef LINE_CLEAR_SCORE_EN
  logic [15:0] score_q;

  always_ff @(posedge clk) begin
    if (reset)
      score_q <= '0;
    else if (state_q == DONE)
      score_q <= score_step(score_q, cnt_q);
  end

  assign score = score_q;
`else
  assign score = '0;
`endif

endmodule
